// File: rtl/urv_lsu.sv
// urv_lsu: registered load/store bus master for the uRV execute stage.
// Steers byte lanes, flags misalignment, aligns and extends load data.
module urv_lsu #(
   parameter int XLEN    = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              x_stall_i,
   input  logic              x_kill_i,
   input  logic              d_valid_i,
   input  logic              d_is_load_i,
   input  logic              d_is_store_i,
   input  logic [2:0]        d_fun_i,
   input  logic [4:0]        d_rd_i,
   input  logic [AW-1:0]     x_addr_i,
   input  logic [XLEN-1:0]   x_store_data_i,
   output logic              x_stall_req_o,
   output logic              x_misaligned_load_o,
   output logic              x_misaligned_store_o,
   output logic              x_bus_error_o,
   output logic [AW-1:0]     dm_addr_o,
   output logic [XLEN-1:0]   dm_data_s_o,
   output logic [XLEN/8-1:0] dm_data_select_o,
   output logic              dm_load_o,
   output logic              dm_store_o,
   input  logic              dm_ready_i,
   input  logic [XLEN-1:0]   dm_data_l_i,
   output logic              w_valid_o,
   output logic              w_rd_write_o,
   output logic [4:0]        w_rd_o,
   output logic [XLEN-1:0]   w_load_value_o
);

   localparam int NB = XLEN / 8;
   localparam int OB = $clog2(NB);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST =
      CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {
      IDLE,
      REQ
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0] sdata_q, sdata_d;
   logic [NB-1:0]   sel_q, sel_d;
   logic            ld_q, ld_d;
   logic            st_q, st_d;
   logic [4:0]      rd_q, rd_d;
   logic [2:0]      fun_q, fun_d;
   logic            killed_q, killed_d;
   logic            wv_q, wv_d;
   logic            wwr_q, wwr_d;
   logic [4:0]      wrd_q, wrd_d;
   logic [XLEN-1:0] wval_q, wval_d;
   logic            berr_q, berr_d;

   logic            sz_b, sz_h, sz_w, sz_d;
   logic            legal, misal, present, accept, tmo;
   logic [7:0]      lmask;
   logic [NB-1:0]   sel_new;
   logic [XLEN-1:0] sdata;
   logic [XLEN-1:0] lsh, lval;
   logic            lmsb;
   int              lnb;

   assign sz_b = d_fun_i[1:0] == 2'b00;
   assign sz_h = d_fun_i[1:0] == 2'b01;
   assign sz_w = d_fun_i[1:0] == 2'b10;
   assign sz_d = d_fun_i[1:0] == 2'b11;

   // D and WU only exist on RV64; funct3 111 never exists.
   always_comb begin
      legal = 1'b1;
      if (d_fun_i == 3'b111)
         legal = 1'b0;
      if (XLEN != 64 && (d_fun_i == 3'b011 || d_fun_i == 3'b110))
         legal = 1'b0;
   end

   always_comb begin
      misal = 1'b0;
      lmask = 8'h01;
      unique case (1'b1)
         sz_b: begin
            misal = 1'b0;
            lmask = 8'h01;
         end
         sz_h: begin
            misal = x_addr_i[0];
            lmask = 8'h03;
         end
         sz_w: begin
            misal = |x_addr_i[1:0];
            lmask = 8'h0f;
         end
         sz_d: begin
            misal = |x_addr_i[2:0];
            lmask = 8'hff;
         end
         default: begin
            misal = 1'b0;
            lmask = 8'h01;
         end
      endcase
   end

   assign present = d_valid_i & (d_is_load_i | d_is_store_i)
                  & !x_kill_i & !x_stall_i & (state_q == IDLE);
   assign accept  = present & legal & !misal;

   assign x_misaligned_load_o  = present & misal & legal & d_is_load_i;
   assign x_misaligned_store_o = present & misal & legal & !d_is_load_i;

   assign sel_new = d_is_load_i ? '0
                  : NB'(lmask) << x_addr_i[OB-1:0];

   // Replicate the low size bytes across every lane.
   always_comb begin
      sdata = '0;
      for (int i = 0; i < NB; i++) begin
         unique case (1'b1)
            sz_b: sdata[8*i +: 8] = x_store_data_i[7:0];
            sz_h: sdata[8*i +: 8] = x_store_data_i[8*(i%2) +: 8];
            sz_w: sdata[8*i +: 8] = x_store_data_i[8*(i%4) +: 8];
            sz_d: sdata[8*i +: 8] = x_store_data_i[8*(i%8) +: 8];
            default: sdata[8*i +: 8] = x_store_data_i[7:0];
         endcase
      end
   end

   always_comb begin
      lsh  = dm_data_l_i >> {addr_q[OB-1:0], 3'b000};
      lval = lsh;
      lnb  = NB;
      lmsb = lsh[XLEN-1];
      unique case (fun_q[1:0])
         2'b00: begin
            lnb  = 1;
            lmsb = lsh[7];
         end
         2'b01: begin
            lnb  = 2;
            lmsb = lsh[15];
         end
         2'b10: begin
            lnb  = 4;
            lmsb = lsh[31];
         end
         default: begin
            lnb  = NB;
            lmsb = lsh[XLEN-1];
         end
      endcase
      for (int i = 0; i < NB; i++) begin
         if (i >= lnb)
            lval[8*i +: 8] = {8{lmsb & !fun_q[2]}};
      end
   end

   assign tmo = (TIMEOUT > 0) && (state_q == REQ)
              && !dm_ready_i && (cnt_q == TO_LAST);

   assign x_stall_req_o = (state_q == REQ) & !dm_ready_i & !tmo;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      sdata_d  = sdata_q;
      sel_d    = sel_q;
      ld_d     = ld_q;
      st_d     = st_q;
      rd_d     = rd_q;
      fun_d    = fun_q;
      killed_d = killed_q;
      wv_d     = 1'b0;
      wwr_d    = 1'b0;
      wrd_d    = wrd_q;
      wval_d   = wval_q;
      berr_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = REQ;
               cnt_d    = '0;
               addr_d   = x_addr_i;
               sdata_d  = sdata;
               sel_d    = sel_new;
               ld_d     = d_is_load_i;
               st_d     = !d_is_load_i;
               rd_d     = d_rd_i;
               fun_d    = d_fun_i;
               killed_d = 1'b0;
            end
         end
         REQ: begin
            // A kill cannot abort the bus cycle; it only suppresses rd write.
            if (x_kill_i)
               killed_d = 1'b1;
            if (dm_ready_i) begin
               state_d = IDLE;
               ld_d    = 1'b0;
               st_d    = 1'b0;
               wv_d    = 1'b1;
               wwr_d   = ld_q & !(killed_q | x_kill_i);
               wrd_d   = rd_q;
               if (ld_q)
                  wval_d = lval;
            end else if (tmo) begin
               state_d = IDLE;
               ld_d    = 1'b0;
               st_d    = 1'b0;
               berr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         sdata_q  <= '0;
         sel_q    <= '0;
         ld_q     <= 1'b0;
         st_q     <= 1'b0;
         rd_q     <= '0;
         fun_q    <= '0;
         killed_q <= 1'b0;
         wv_q     <= 1'b0;
         wwr_q    <= 1'b0;
         wrd_q    <= '0;
         wval_q   <= '0;
         berr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         sdata_q  <= sdata_d;
         sel_q    <= sel_d;
         ld_q     <= ld_d;
         st_q     <= st_d;
         rd_q     <= rd_d;
         fun_q    <= fun_d;
         killed_q <= killed_d;
         wv_q     <= wv_d;
         wwr_q    <= wwr_d;
         wrd_q    <= wrd_d;
         wval_q   <= wval_d;
         berr_q   <= berr_d;
      end
   end

   assign dm_addr_o        = addr_q;
   assign dm_data_s_o      = sdata_q;
   assign dm_data_select_o = sel_q;
   assign dm_load_o        = ld_q;
   assign dm_store_o       = st_q;
   assign w_valid_o        = wv_q;
   assign w_rd_write_o     = wwr_q;
   assign w_rd_o           = wrd_q;
   assign w_load_value_o   = wval_q;
   assign x_bus_error_o    = berr_q;

endmodule

// File: tb/tb_urv_lsu.sv
// tb_urv_lsu: drives an RV32 (no timeout) and an RV64 (TIMEOUT=4) LSU
// with shared stimulus and checks both against a transaction-level model.
module tb_urv_lsu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        x_stall, x_kill, d_valid, d_ld, d_st;
   logic [2:0]  d_fun;
   logic [4:0]  d_rd;
   logic [31:0] x_addr;
   logic [63:0] x_sd;
   logic        dm_ready;
   logic [63:0] dm_dl;

   logic        o32_stall, o32_mal, o32_mas, o32_berr;
   logic [31:0] o32_addr, o32_ds, o32_wval;
   logic [3:0]  o32_sel;
   logic        o32_ld, o32_st, o32_wv, o32_wwr;
   logic [4:0]  o32_wrd;

   logic        o64_stall, o64_mal, o64_mas, o64_berr;
   logic [31:0] o64_addr;
   logic [63:0] o64_ds, o64_wval;
   logic [7:0]  o64_sel;
   logic        o64_ld, o64_st, o64_wv, o64_wwr;
   logic [4:0]  o64_wrd;

   urv_lsu #(.XLEN(32), .AW(32), .TIMEOUT(0)) u32 (
      .clk_i(clk), .rst_i(rst_n),
      .x_stall_i(x_stall), .x_kill_i(x_kill),
      .d_valid_i(d_valid), .d_is_load_i(d_ld), .d_is_store_i(d_st),
      .d_fun_i(d_fun), .d_rd_i(d_rd),
      .x_addr_i(x_addr), .x_store_data_i(x_sd[31:0]),
      .x_stall_req_o(o32_stall),
      .x_misaligned_load_o(o32_mal), .x_misaligned_store_o(o32_mas),
      .x_bus_error_o(o32_berr),
      .dm_addr_o(o32_addr), .dm_data_s_o(o32_ds),
      .dm_data_select_o(o32_sel),
      .dm_load_o(o32_ld), .dm_store_o(o32_st),
      .dm_ready_i(dm_ready), .dm_data_l_i(dm_dl[31:0]),
      .w_valid_o(o32_wv), .w_rd_write_o(o32_wwr),
      .w_rd_o(o32_wrd), .w_load_value_o(o32_wval)
   );

   urv_lsu #(.XLEN(64), .AW(32), .TIMEOUT(4)) u64 (
      .clk_i(clk), .rst_i(rst_n),
      .x_stall_i(x_stall), .x_kill_i(x_kill),
      .d_valid_i(d_valid), .d_is_load_i(d_ld), .d_is_store_i(d_st),
      .d_fun_i(d_fun), .d_rd_i(d_rd),
      .x_addr_i(x_addr), .x_store_data_i(x_sd),
      .x_stall_req_o(o64_stall),
      .x_misaligned_load_o(o64_mal), .x_misaligned_store_o(o64_mas),
      .x_bus_error_o(o64_berr),
      .dm_addr_o(o64_addr), .dm_data_s_o(o64_ds),
      .dm_data_select_o(o64_sel),
      .dm_load_o(o64_ld), .dm_store_o(o64_st),
      .dm_ready_i(dm_ready), .dm_data_l_i(dm_dl),
      .w_valid_o(o64_wv), .w_rd_write_o(o64_wwr),
      .w_rd_o(o64_wrd), .w_load_value_o(o64_wval)
   );

   logic        a_stall[2], a_mal[2], a_mas[2], a_berr[2];
   logic        a_ld[2], a_st[2], a_wv[2], a_wwr[2];
   logic [31:0] a_addr[2];
   logic [63:0] a_ds[2], a_wval[2];
   logic [7:0]  a_sel[2];
   logic [4:0]  a_wrd[2];

   always_comb begin
      a_stall[0] = o32_stall;  a_stall[1] = o64_stall;
      a_mal[0]   = o32_mal;    a_mal[1]   = o64_mal;
      a_mas[0]   = o32_mas;    a_mas[1]   = o64_mas;
      a_berr[0]  = o32_berr;   a_berr[1]  = o64_berr;
      a_ld[0]    = o32_ld;     a_ld[1]    = o64_ld;
      a_st[0]    = o32_st;     a_st[1]    = o64_st;
      a_wv[0]    = o32_wv;     a_wv[1]    = o64_wv;
      a_wwr[0]   = o32_wwr;    a_wwr[1]   = o64_wwr;
      a_addr[0]  = o32_addr;   a_addr[1]  = o64_addr;
      a_ds[0]    = {32'd0, o32_ds};
      a_ds[1]    = o64_ds;
      a_wval[0]  = {32'd0, o32_wval};
      a_wval[1]  = o64_wval;
      a_sel[0]   = {4'd0, o32_sel};
      a_sel[1]   = o64_sel;
      a_wrd[0]   = o32_wrd;    a_wrd[1]   = o64_wrd;
   end

   int checks = 0;
   int fails  = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int xl(int k);
      return (k == 0) ? 32 : 64;
   endfunction

   function automatic int tmo_of(int k);
      return (k == 0) ? 0 : 4;
   endfunction

   function automatic int sz(logic [2:0] f);
      return 1 << f[1:0];
   endfunction

   function automatic bit legal(int k, logic [2:0] f);
      if (f == 3'd7) return 1'b0;
      if (xl(k) == 32 && (f == 3'd3 || f == 3'd6)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [63:0] xmask(int k);
      return (xl(k) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
   endfunction

   function automatic logic [63:0] exp_ds(int k, logic [63:0] d,
                                          logic [2:0] f);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < xl(k) / 8; i++)
         r[8*i +: 8] = d[8*(i % sz(f)) +: 8];
      return r;
   endfunction

   function automatic logic [7:0] exp_sel(int k, logic [31:0] a,
                                          logic [2:0] f);
      int s, off;
      s   = sz(f);
      off = int'(a % (xl(k) / 8));
      return 8'(((1 << s) - 1) << off);
   endfunction

   function automatic logic [63:0] exp_load(int k, logic [31:0] a,
                                            logic [2:0] f,
                                            logic [63:0] dl);
      int s, off;
      logic [63:0] v, m;
      s   = sz(f);
      off = int'(a % (xl(k) / 8));
      v   = (dl & xmask(k)) >> (8 * off);
      m   = (s == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * s)) - 1);
      v   = v & m;
      if (!f[2] && v[8*s-1]) v = v | ~m;
      return v & xmask(k);
   endfunction

   bit          m_busy[2], m_kill[2], m_isld[2];
   int          m_wait[2];
   logic [31:0] m_addr[2];
   logic [2:0]  m_fun[2];
   logic [4:0]  m_rd[2];

   logic        e_ld[2], e_st[2], e_wv[2], e_wwr[2], e_berr[2];
   logic [31:0] e_addr[2];
   logic [63:0] e_ds[2], e_wval[2];
   logic [7:0]  e_sel[2];
   logic [4:0]  e_wrd[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 0; m_kill[k] = 0; m_isld[k] = 0; m_wait[k] = 0;
         m_addr[k] = '0; m_fun[k] = '0; m_rd[k] = '0;
         e_ld[k] = 0; e_st[k] = 0; e_wv[k] = 0; e_wwr[k] = 0;
         e_berr[k] = 0; e_addr[k] = '0; e_ds[k] = '0;
         e_wval[k] = '0; e_sel[k] = '0; e_wrd[k] = '0;
      end
   endtask

   function automatic bit times_out(int k);
      return tmo_of(k) > 0 && m_wait[k] == tmo_of(k) - 1;
   endfunction

   task automatic model_step(int k);
      bit pres, mis;
      pres = d_valid && (d_ld || d_st) && !x_kill && !x_stall && !m_busy[k];
      mis  = (x_addr % sz(d_fun)) != 0;
      e_wv[k]   = 0;
      e_wwr[k]  = 0;
      e_berr[k] = 0;
      if (m_busy[k]) begin
         if (x_kill) m_kill[k] = 1;
         if (dm_ready) begin
            m_busy[k] = 0;
            e_ld[k]   = 0;
            e_st[k]   = 0;
            e_wv[k]   = 1;
            e_wwr[k]  = m_isld[k] && !m_kill[k];
            e_wrd[k]  = m_rd[k];
            if (m_isld[k])
               e_wval[k] = exp_load(k, m_addr[k], m_fun[k], dm_dl);
         end else if (times_out(k)) begin
            m_busy[k] = 0;
            e_ld[k]   = 0;
            e_st[k]   = 0;
            e_berr[k] = 1;
         end else begin
            m_wait[k]++;
         end
      end else if (pres && legal(k, d_fun) && !mis) begin
         m_busy[k] = 1;
         m_wait[k] = 0;
         m_kill[k] = 0;
         m_isld[k] = d_ld;
         m_addr[k] = x_addr;
         m_fun[k]  = d_fun;
         m_rd[k]   = d_rd;
         e_ld[k]   = d_ld;
         e_st[k]   = !d_ld;
         e_addr[k] = x_addr;
         e_ds[k]   = exp_ds(k, x_sd, d_fun);
         e_sel[k]  = d_ld ? 8'h00 : exp_sel(k, x_addr, d_fun);
      end
   endtask

   task automatic check_regs(int k);
      chk($sformatf("dm_load[%0d]", k), a_ld[k], e_ld[k]);
      chk($sformatf("dm_store[%0d]", k), a_st[k], e_st[k]);
      chk($sformatf("bus_err[%0d]", k), a_berr[k], e_berr[k]);
      chk($sformatf("w_valid[%0d]", k), a_wv[k], e_wv[k]);
      chk($sformatf("dm_addr[%0d]", k), a_addr[k], e_addr[k]);
      chk($sformatf("dm_sel[%0d]", k), a_sel[k], e_sel[k]);
      if (e_st[k])
         chk($sformatf("dm_data_s[%0d]", k), a_ds[k], e_ds[k]);
      if (e_wv[k]) begin
         chk($sformatf("w_rd_write[%0d]", k), a_wwr[k], e_wwr[k]);
         chk($sformatf("w_rd[%0d]", k), a_wrd[k], e_wrd[k]);
         if (e_wwr[k])
            chk($sformatf("w_load_value[%0d]", k), a_wval[k], e_wval[k]);
      end
   endtask

   task automatic check_comb(int k);
      bit pres, mis, lg;
      pres = d_valid && (d_ld || d_st) && !x_kill && !x_stall && !m_busy[k];
      mis  = (x_addr % sz(d_fun)) != 0;
      lg   = legal(k, d_fun);
      chk($sformatf("mis_load[%0d]", k), a_mal[k], pres && lg && mis && d_ld);
      chk($sformatf("mis_store[%0d]", k), a_mas[k],
          pres && lg && mis && !d_ld);
      chk($sformatf("stall_req[%0d]", k), a_stall[k],
          m_busy[k] && !dm_ready && !times_out(k));
   endtask

   // ---------------- cycle plumbing ----------------
   task automatic cyc();
      @(negedge clk);
      check_regs(0);
      check_regs(1);
   endtask

   task automatic commit();
      #1;
      check_comb(0);
      check_comb(1);
      model_step(0);
      model_step(1);
   endtask

   task automatic set_idle();
      d_valid = 0; d_ld = 0; d_st = 0; d_fun = '0; d_rd = '0;
      x_addr = '0; x_sd = '0; x_kill = 0; x_stall = 0;
      dm_ready = 0; dm_dl = '0;
   endtask

   task automatic drive(int op, logic [2:0] f, logic [31:0] a,
                        logic [63:0] sd, logic rdy, logic [63:0] dl,
                        logic kill);
      cyc();
      d_valid  = (op != 0);
      d_ld     = (op == 1);
      d_st     = (op == 2);
      d_fun    = f;
      d_rd     = 5'd3;
      x_addr   = a;
      x_sd     = sd;
      x_kill   = kill;
      x_stall  = 0;
      dm_ready = rdy;
      dm_dl    = dl;
      commit();
   endtask

   task automatic idle(logic rdy, logic [63:0] dl = '0, logic kill = 0);
      drive(0, 3'd0, 32'd0, 64'd0, rdy, dl, kill);
   endtask

   task automatic do_reset();
      set_idle();
      @(negedge clk);
      rst_n = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_ld[%0d]", k), a_ld[k], 0);
         chk($sformatf("rst_st[%0d]", k), a_st[k], 0);
         chk($sformatf("rst_addr[%0d]", k), a_addr[k], 0);
         chk($sformatf("rst_ds[%0d]", k), a_ds[k], 0);
         chk($sformatf("rst_sel[%0d]", k), a_sel[k], 0);
         chk($sformatf("rst_wv[%0d]", k), a_wv[k], 0);
         chk($sformatf("rst_wwr[%0d]", k), a_wwr[k], 0);
         chk($sformatf("rst_wrd[%0d]", k), a_wrd[k], 0);
         chk($sformatf("rst_wval[%0d]", k), a_wval[k], 0);
         chk($sformatf("rst_berr[%0d]", k), a_berr[k], 0);
         chk($sformatf("rst_stall[%0d]", k), a_stall[k], 0);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      int rdy_pct;
      int r;
      rst_n = 0;
      set_idle();
      model_reset();
      do_reset();

      // SW 0x104 on RV32: one request cycle, full-word select.
      drive(2, 3'd2, 32'h104, 64'hDEADBEEF, 1, 0, 0);
      idle(1);
      chk("t1_store", a_st[0], 1);
      chk("t1_sel", a_sel[0], 8'h0F);
      chk("t1_ds", a_ds[0], 64'hDEADBEEF);
      idle(0);
      chk("t1_wv", a_wv[0], 1);
      chk("t1_wwr", a_wwr[0], 0);
      chk("t1_store_drop", a_st[0], 0);

      // LB / LBU at 0x103.
      drive(1, 3'd0, 32'h103, 0, 0, 0, 0);
      idle(1, 64'h80AABBCC);
      idle(0);
      chk("t2_lb", a_wval[0], 64'hFFFF_FF80);
      drive(1, 3'd4, 32'h103, 0, 0, 0, 0);
      idle(1, 64'h80AABBCC);
      idle(0);
      chk("t2_lbu", a_wval[0], 64'h0000_0080);

      // RV64 SH 0x6 and LWU 0x4.
      drive(2, 3'd1, 32'h6, 64'h1234, 0, 0, 0);
      idle(1);
      chk("t3_sel", a_sel[1], 8'hC0);
      chk("t3_ds", a_ds[1], 64'h1234_1234_1234_1234);
      idle(0);
      drive(1, 3'd6, 32'h4, 0, 0, 0, 0);
      idle(1, 64'h89ABCDEF_00000000);
      idle(0);
      chk("t3_lwu", a_wval[1], 64'h0000_0000_89AB_CDEF);

      // Misaligned LW, then LD on RV32.
      drive(1, 3'd2, 32'h102, 0, 1, 0, 0);
      chk("t4_mis", a_mal[0], 1);
      idle(1);
      chk("t4_noreq", a_ld[0], 0);
      idle(0);
      chk("t4_nowv", a_wv[0], 0);
      drive(1, 3'd3, 32'h0, 0, 0, 0, 0);
      chk("t4_ld32", a_mal[0], 0);
      idle(1);
      chk("t4_ld32_noreq", a_ld[0], 0);
      idle(0);

      // Ready low three cycles.
      drive(1, 3'd2, 32'h200, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         idle(0);
         chk("t5_stall", a_stall[0], 1);
         chk("t5_hold", a_addr[0], 32'h200);
      end
      idle(1);
      chk("t5_stall_done", a_stall[0], 0);
      idle(0);
      chk("t5_wv", a_wv[0], 1);

      // RV64 timeout after four request cycles.
      drive(1, 3'd2, 32'h300, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         idle(0);
         chk("t5_req64", a_ld[1], 1);
      end
      chk("t5_tmo_stall", a_stall[1], 0);
      idle(0);
      chk("t5_berr", a_berr[1], 1);
      chk("t5_drop", a_ld[1], 0);
      chk("t5_berr_nowv", a_wv[1], 0);
      idle(0);
      chk("t5_berr_pulse", a_berr[1], 0);
      idle(1);
      idle(0);

      // Reset mid-request.
      drive(2, 3'd2, 32'h20, 64'h55, 0, 0, 0);
      idle(0);
      chk("t6_req", a_st[0], 1);
      do_reset();

      // Kill during request.
      drive(1, 3'd2, 32'h10, 0, 0, 0, 0);
      idle(0, 0, 1);
      idle(1);
      idle(0);
      chk("t6_kill_wv", a_wv[0], 1);
      chk("t6_kill_wwr", a_wwr[0], 0);

      // Randomised traffic.
      rdy_pct = 70;
      for (int i = 0; i < 4000; i++) begin
         if (i % 500 == 0)
            rdy_pct = $urandom_range(20, 95);
         if (i % 1300 == 1299) begin
            do_reset();
            continue;
         end
         cyc();
         r        = $urandom_range(0, 7);
         d_valid  = $urandom_range(0, 9) != 0;
         d_ld     = (r >= 1 && r <= 4);
         d_st     = (r >= 5);
         d_fun    = 3'($urandom_range(0, 7));
         d_rd     = 5'($urandom);
         x_addr   = $urandom & 32'h0000_0FFF;
         if ($urandom_range(0, 1) == 1)
            x_addr = x_addr & ~(32'(sz(d_fun)) - 32'd1);
         x_sd     = {$urandom, $urandom};
         x_kill   = $urandom_range(0, 9) == 0;
         x_stall  = $urandom_range(0, 9) == 0;
         dm_ready = $urandom_range(1, 100) <= rdy_pct;
         dm_dl    = {$urandom, $urandom};
         commit();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/urv_lsu.md
# urv_lsu

Parametrised load/store unit for the uRV execute stage. It replaces the single-cycle combinational store-select logic with a registered request/ready bus master, and adds:
- XLEN-generic byte-lane steering (32 or 64 bit);
- misaligned-access detection;
- load data alignment with sign/zero extension;
- an optional bus timeout.

It sits between exec (address/operands) and writeback (load result), and drives the data-memory interface.

## Interface
- XLEN, 32, data width; 32 or 64 only. NB = XLEN/8 lanes, OB = log2(NB).
- AW, 32, address width.
- TIMEOUT, 0, cycles to wait for dm_ready_i before bus error; 0 = never time out.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- x_stall_i  in  1  pipeline stall; blocks acceptance.
- x_kill_i  in  1  pipeline kill; blocks acceptance.
- d_valid_i  in  1  instruction valid.
- d_is_load_i, d_is_store_i  in  1 each  operation type.
- d_fun_i  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- d_rd_i  in  5  load destination register.
- x_addr_i  in  AW  effective address.
- x_store_data_i  in  XLEN  rs2 value.
- x_stall_req_o  out  1  stall request to pipeline control.
- x_misaligned_load_o, x_misaligned_store_o  out  1 each  to the exception unit.
- x_bus_error_o  out  1  one-cycle pulse on timeout.
- dm_addr_o  out  AW  request address.
- dm_data_s_o  out  XLEN  store data.
- dm_data_select_o  out  NB  byte-lane enables.
- dm_load_o, dm_store_o  out  1 each  request; held high until accepted.
- dm_ready_i  in  1  request accepted / load data valid.
- dm_data_l_i  in  XLEN  load data.
- w_valid_o  out  1  one-cycle completion pulse.
- w_rd_write_o  out  1  1 for a completed load, 0 for a store.
- w_rd_o  out  5  destination register.
- w_load_value_o  out  XLEN  aligned, extended load value.

## Operation

**Present condition.** present = d_valid_i & (d_is_load_i | d_is_store_i) & !x_kill_i & !x_stall_i & state==IDLE.

**Size.** B = 1 byte, H = 2, W = 4, D = 8.
- D and WU are legal only when XLEN=64.
- funct3 111 is illegal.
- Illegal sizes are never accepted and flag nothing; the decoder raises undef.

**Misalignment.** An access is misaligned when addr mod size != 0.
- Combinational, same cycle: x_misaligned_load_o / x_misaligned_store_o = present & misaligned & legal.
- A misaligned access issues no bus request and produces no w_valid_o.

**Accept.** accept = present & legal & !misaligned. At that edge the block registers:
- dm_addr_o = x_addr_i.
- dm_data_s_o = low size bytes of store data, replicated across all lanes.
- dm_data_select_o = ((1<<size)-1) << addr[OB-1:0]; zero for loads.
- rd and funct3 for writeback.

**FSM.**
- IDLE -> REQ on accept; dm_load_o or dm_store_o goes high.
- REQ -> IDLE when dm_ready_i=1 (complete).
- REQ -> IDLE when TIMEOUT>0 and the counter reaches TIMEOUT-1 with dm_ready_i=0 (timeout).
- The counter clears on accept.

**Complete.**
- Next cycle: w_valid_o=1, w_rd_o = registered rd, w_rd_write_o = load.
- Loads: w_load_value_o = (dm_data_l_i >> 8*addr[OB-1:0]) truncated to size, then sign-extended (B/H/W/D) or zero-extended (BU/HU/WU) to XLEN.
- Load data is sampled on the dm_ready_i edge.

**Timeout.**
- Request drops.
- Next cycle: x_bus_error_o=1 and w_valid_o=0.

**Stall and kill.**
- x_stall_req_o = (state==REQ) & !dm_ready_i, and is also 0 in the timeout cycle.
- x_kill_i during REQ does not abort the bus transaction. The completion still occurs but is reported with w_rd_write_o=0 (killed flag latched).

**Reset.** Asynchronous at any time, including mid-REQ:
- state IDLE;
- all outputs 0: dm_*, w_*, x_stall_req_o, x_bus_error_o, counter.

## Timing
- Cycle 0: present & accept sampled at edge E0.
- Cycle 1: dm_*_o valid and stable until dm_ready_i is sampled high.
- If ready at E1, w_valid_o is high in cycle 2. Minimum latency is 2 cycles, back-to-back throughput 1 op per 2 cycles.
- dm_addr_o, dm_data_s_o and dm_data_select_o do not change while in REQ.
- w_valid_o and x_bus_error_o are one-cycle pulses, never both high.
- Misaligned flags are combinational in cycle 0 and otherwise 0.
- Ops presented while in REQ are not accepted; the pipeline is stalled by x_stall_req_o.

## Test plan
1. XLEN=32, SW addr 0x104, data 0xDEADBEEF, ready immediate -> dm_store_o 1 cycle, select 1111, w_valid_o with w_rd_write_o=0 two cycles after present.
2. XLEN=32, LB addr 0x103, dm_data_l_i 0x80AABBCC -> w_load_value_o 0xFFFFFF80. Same with LBU -> 0x00000080.
3. XLEN=64, SH addr 0x6, data 0x1234 -> select 0xC0, dm_data_s_o 0x1234 replicated ×4. LWU addr 0x4, data 0x89ABCDEF_00000000 -> 0x00000000_89ABCDEF.
4. LW addr 0x102 -> x_misaligned_load_o=1 same cycle, no dm_load_o, no w_valid_o. LD on XLEN=32 -> nothing asserted.
5. dm_ready_i held low 3 cycles, TIMEOUT=0 -> x_stall_req_o high 3 cycles, request stable, completes on 4th. TIMEOUT=4 with ready never -> x_bus_error_o pulse, request dropped after 4 cycles.
6. Reset asserted mid-REQ -> all outputs 0 immediately. x_kill_i during REQ -> completion with w_rd_write_o=0.
